// File: rtl/mips_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states and the
// divide-by-zero LO pattern.
package mips_pkg;

  typedef enum logic [2:0] {
    MD_MULTU = 3'b000,
    MD_MULT  = 3'b001,
    MD_DIVU  = 3'b010,
    MD_DIV   = 3'b011,
    MD_MADDU = 3'b100,
    MD_MADD  = 3'b101
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } md_state_e;

  // All-ones quotient reported for b == 0; sliced down to the operand width.
  localparam logic [127:0] MD_DIV0_LO = {128{1'b1}};

endpackage

// File: rtl/muldiv_iter.sv
// One iteration of the multiply/divide datapath: a shift-add step for multiply
// or a restoring-subtract step for divide over a {upper, lower} accumulator.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic               div_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   shl_s;
  logic [WIDTH-1:0] diff_s;
  logic             ge_s;

  // Divide keeps {remainder, quotient}; the shifted remainder can need one
  // extra bit, but after a successful subtract it always fits in WIDTH bits.
  always_comb begin
    sum_s  = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
    shl_s  = acc_i[2*WIDTH-1:WIDTH-1];
    ge_s   = (shl_s >= {1'b0, opnd_i});
    diff_s = shl_s[WIDTH-1:0] - opnd_i;
    if (div_i) begin
      if (ge_s) begin
        acc_o = {diff_s, acc_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = {shl_s[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o = {sum_s, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO. Define MULDIV_MADD_EN to add the
// MADDU/MADD accumulate ops; without it op codes 1xx are rejected.
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  md_state_e          state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   a_raw_q;
  logic               div_q;
  logic               div0_q;
  logic               neg_res_q;
  logic               neg_rem_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
`ifdef MULDIV_MADD_EN
  logic               madd_q;
`endif

  logic               op_ok_s;
  logic               op_div_s;
  logic               a_neg_s;
  logic               b_neg_s;
  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   fix_hi_s;
  logic [WIDTH-1:0]   fix_lo_s;

  // Decode which ops are accepted and whether they take the divide path.
  always_comb begin
    case (op)
      MD_MULTU, MD_MULT: begin op_ok_s = 1'b1; op_div_s = 1'b0; end
      MD_DIVU, MD_DIV:   begin op_ok_s = 1'b1; op_div_s = 1'b1; end
`ifdef MULDIV_MADD_EN
      MD_MADDU, MD_MADD: begin op_ok_s = 1'b1; op_div_s = 1'b0; end
`endif
      default:           begin op_ok_s = 1'b0; op_div_s = 1'b0; end
    endcase
  end

  // Operand magnitudes; as unsigned WIDTH-bit values even |MIN| is exact.
  always_comb begin
    a_neg_s = op[0] & a[WIDTH-1];
    b_neg_s = op[0] & b[WIDTH-1];
    a_mag_s = a_neg_s ? (-a) : a;
    b_mag_s = b_neg_s ? (-b) : b;
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .div_i  (div_q),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (acc_d)
  );

  // Sign fix-up and final HI/LO values written in FIX.
  always_comb begin
    prod_s = neg_res_q ? (-acc_q) : acc_q;
    if (div_q) begin
      if (div0_q) begin
        fix_hi_s = a_raw_q;
        fix_lo_s = MD_DIV0_LO[WIDTH-1:0];
      end else begin
        fix_hi_s = neg_rem_q ? (-acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
        fix_lo_s = neg_res_q ? (-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
      end
    end else begin
`ifdef MULDIV_MADD_EN
      if (madd_q) begin
        {fix_hi_s, fix_lo_s} = {hi_q, lo_q} + prod_s;
      end else begin
        {fix_hi_s, fix_lo_s} = prod_s;
      end
`else
      {fix_hi_s, fix_lo_s} = prod_s;
`endif
    end
  end

  // Control FSM, iteration counter, operand latches and HI/LO registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      a_raw_q   <= '0;
      div_q     <= 1'b0;
      div0_q    <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
`ifdef MULDIV_MADD_EN
      madd_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (wr_hi) hi_q <= wd;
          if (wr_lo) lo_q <= wd;
          if (start && !flush && op_ok_s) begin
            state_q   <= op_div_s ? ST_DIV : ST_MUL;
            busy_q    <= 1'b1;
            cnt_q     <= CNT_INIT;
            acc_q     <= {{WIDTH{1'b0}}, a_mag_s};
            opnd_q    <= b_mag_s;
            a_raw_q   <= a;
            div_q     <= op_div_s;
            div0_q    <= op_div_s && (b == '0);
            neg_res_q <= a_neg_s ^ b_neg_s;
            neg_rem_q <= a_neg_s;
`ifdef MULDIV_MADD_EN
            madd_q    <= op[2];
`endif
          end
        end
        ST_MUL, ST_DIV: begin
          if (flush) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_LAST) state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          if (!flush) begin
            hi_q   <= fix_hi_s;
            lo_q   <= fix_lo_s;
            done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed ops push expected HI/LO and done
// cycle; a negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         flush = 1'b0;
  logic         wr_hi = 1'b0;
  logic         wr_lo = 1'b0;
  logic [W-1:0] wd = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  typedef struct {
    logic [W-1:0] ehi;
    logic [W-1:0] elo;
    int           ecyc;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errors = 0;
  int   cyc = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .wr_hi(wr_hi), .wr_lo(wr_lo), .wd(wd),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && done) begin
      if (sb.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_done: got done=1 hi=%0h lo=%0h, expected no done (cycle %0d)", hi, lo, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_hi", {32'h0, hi}, {32'h0, e.ehi});
        chk("result_lo", {32'h0, lo}, {32'h0, e.elo});
        chk("done_cycle", 64'(cyc), 64'(e.ecyc));
      end
    end
  end

  // Called at a negedge: presents start for one cycle.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] ehi, input logic [W-1:0] elo, input bit push);
    start = 1'b1; op = o; a = av; b = bv;
    if (push) sb.push_back('{ehi, elo, cyc + W + 2});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo);
    int n;
    issue(o, av, bv, ehi, elo, 1'b1);
    wait_idle(n);
    chk("busy_len", 64'(n), 64'(W + 1));
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_done", {63'h0, done}, 64'h0);
    chk("rst_hi", {32'h0, hi}, 64'h0);
    chk("rst_lo", {32'h0, lo}, 64'h0);
    rst = 1'b1;
    @(negedge clk);

    // Directed vectors; consecutive run_op calls start in the done cycle.
    run_op(3'b001, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op(3'b011, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op(3'b010, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF);
    run_op(3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_op(3'b010, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E);
    run_op(3'b011, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    run_op(3'b001, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006);
    run_op(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run_op(3'b011, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF);
    run_op(3'b001, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB);
    run_op(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    @(negedge clk);

    // Flush mid-operation: no done, HI/LO keep the last result.
    issue(3'b000, 32'd5, 32'd6, 32'h0, 32'h0, 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {63'h0, busy}, 64'h0);
    repeat (40) @(negedge clk);
    chk("flush_hi", {32'h0, hi}, 64'hFFFFFFFE);
    chk("flush_lo", {32'h0, lo}, 64'h00000001);

    wr_lo = 1'b1; wd = 32'h00001234;
    @(negedge clk);
    wr_lo = 1'b0;
    chk("mtlo", {32'h0, lo}, 64'h00001234);

    // mthi while busy is ignored.
    issue(3'b000, 32'd2, 32'd3, 32'h0, 32'h0, 1'b0);
    wr_hi = 1'b1; wd = 32'h0000DEAD;
    @(negedge clk);
    wr_hi = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("mthi_busy_ignored", {32'h0, hi}, 64'hFFFFFFFE);

    // Flush landing on the FIX edge suppresses the write.
    issue(3'b000, 32'd2, 32'd3, 32'h0, 32'h0, 1'b0);
    repeat (32) @(negedge clk);
    chk("pre_fix_busy", {63'h0, busy}, 64'h1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fixflush_busy", {63'h0, busy}, 64'h0);
    chk("fixflush_hi", {32'h0, hi}, 64'hFFFFFFFE);
    chk("fixflush_lo", {32'h0, lo}, 64'h00001234);

    // mthi together with an accepted start: write lands, result overwrites.
    wr_hi = 1'b1; wd = 32'h0000ABCD;
    issue(3'b000, 32'd3, 32'd4, 32'h0, 32'h0000000C, 1'b1);
    wr_hi = 1'b0;
    chk("mthi_with_start", {32'h0, hi}, 64'h0000ABCD);
    wait_idle(n);
    chk("busy_len_wr", 64'(n), 64'(W + 1));
    @(negedge clk);

    // Undefined ops leave the unit idle.
    issue(3'b110, 32'd1, 32'd1, 32'h0, 32'h0, 1'b0);
    chk("undef110_busy", {63'h0, busy}, 64'h0);
`ifdef MULDIV_MADD_EN
    wr_hi = 1'b1; wd = 32'h00000000;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b1; wd = 32'hFFFFFFFF;
    @(negedge clk);
    wr_lo = 1'b0;
    run_op(3'b100, 32'd1, 32'd1, 32'h00000001, 32'h00000000);
    run_op(3'b101, 32'hFFFFFFFF, 32'd1, 32'h00000000, 32'hFFFFFFFF);
`else
    issue(3'b100, 32'd1, 32'd1, 32'h0, 32'h0, 1'b0);
    chk("undef100_busy", {63'h0, busy}, 64'h0);
    issue(3'b101, 32'd1, 32'd1, 32'h0, 32'h0, 1'b0);
    chk("undef101_busy", {63'h0, busy}, 64'h0);
`endif
    repeat (40) @(negedge clk);

    // Asynchronous reset mid-operation clears everything at once.
    issue(3'b001, 32'd7, 32'd9, 32'h0, 32'h0, 1'b0);
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_busy", {63'h0, busy}, 64'h0);
    chk("arst_done", {63'h0, done}, 64'h0);
    chk("arst_hi", {32'h0, hi}, 64'h0);
    chk("arst_lo", {32'h0, lo}, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("arst_no_result_lo", {32'h0, lo}, 64'h0);

    chk("scoreboard_empty", 64'(sb.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
